// File: rtl/hh_membrane_update.sv
// rtl/hh_membrane_update.sv - Hodgkin-Huxley membrane integrator on one shared multiplier
// Define HH_SPIKE_COUNT_EN to add the saturating 8-bit spike_count output.
module hh_membrane_update #(
  parameter int G_NA     = 120,
  parameter int G_K      = 36,
  parameter int G_L_X10  = 3,
  parameter int E_NA     = 50,
  parameter int E_K      = -77,
  parameter int E_L      = -54,
  parameter int V_REST   = -65,
  parameter int DT_SHIFT = 6,
  parameter int SPIKE_MV = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        m_in,
  input  logic [15:0]        h_in,
  input  logic [15:0]        n_in,
  input  logic signed [15:0] i_ext,
  output logic               out_valid,
  output logic signed [15:0] v_q,
  output logic signed [15:0] v_mv,
  output logic               spike
`ifdef HH_SPIKE_COUNT_EN
  , output logic [7:0]       spike_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_M2, S_M3, S_MH, S_N2, S_N4, S_INA, S_IK, S_IL, S_SUM
  } state_t;

  localparam logic signed [24:0] ENA_Q   = 25'(E_NA * 64);
  localparam logic signed [24:0] EK_Q    = 25'(E_K * 64);
  localparam logic signed [24:0] EL_Q    = 25'(E_L * 64);
  localparam logic signed [24:0] GL_C    = 25'(G_L_X10 * 100);
  localparam logic [17:0]        GNA_C   = 18'(G_NA);
  localparam logic [17:0]        GK_C    = 18'(G_K);
  localparam logic signed [15:0] V_RST_Q = 16'(V_REST * 64);
  localparam logic signed [15:0] SPK_MV  = 16'(SPIKE_MV);

  state_t state, state_nxt;
  logic accept;

  logic [10:0]        m_r, h_r, n_r, ga, gb;
  logic signed [15:0] iext_r;
  logic signed [31:0] i_na, i_k, i_l;

  logic signed [24:0] mul_a, mul_b;
  logic signed [47:0] prod, sc_res;
  logic [10:0]        gate_res;

  logic signed [33:0] i_net, dv;
  logic signed [34:0] v_sum;
  logic signed [15:0] v_new;
  logic               spike_now;

  function automatic logic [10:0] clamp_in(input logic [15:0] x);
    return (x > 16'd1000) ? 11'd1000 : x[10:0];
  endfunction

  // Rounded divide-by-1000: 1049/2^20 ~= 1/1000, floor after +0.5.
  function automatic logic signed [47:0] sc(input logic signed [47:0] x);
    logic signed [47:0] t;
    t = x * 48'sd1049 + 48'sd524288;
    return t >>> 20;
  endfunction

  function automatic logic [10:0] clamp_gate(input logic signed [47:0] x);
    if (x < 48'sd0)         return 11'd0;
    else if (x > 48'sd1000) return 11'd1000;
    else                    return x[10:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Ready during SUM as well so a new sample can start back-to-back.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_M2;
      end
      S_M2:  state_nxt = S_M3;
      S_M3:  state_nxt = S_MH;
      S_MH:  state_nxt = S_N2;
      S_N2:  state_nxt = S_N4;
      S_N4:  state_nxt = S_INA;
      S_INA: state_nxt = S_IK;
      S_IK:  state_nxt = S_IL;
      S_IL:  state_nxt = S_SUM;
      S_SUM: begin
        in_ready  = 1'b1;
        state_nxt = in_valid ? S_M2 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_M2: begin mul_a = $signed({14'd0, m_r}); mul_b = $signed({14'd0, m_r}); end
      S_M3: begin mul_a = $signed({14'd0, ga});  mul_b = $signed({14'd0, m_r}); end
      S_MH: begin mul_a = $signed({14'd0, ga});  mul_b = $signed({14'd0, h_r}); end
      S_N2: begin mul_a = $signed({14'd0, n_r}); mul_b = $signed({14'd0, n_r}); end
      S_N4: begin mul_a = $signed({14'd0, gb});  mul_b = $signed({14'd0, gb});  end
      S_INA: begin
        mul_a = $signed({7'd0, 18'(ga) * GNA_C});
        mul_b = 25'(v_q) - ENA_Q;
      end
      S_IK: begin
        mul_a = $signed({7'd0, 18'(gb) * GK_C});
        mul_b = 25'(v_q) - EK_Q;
      end
      S_IL: begin
        mul_a = GL_C;
        mul_b = 25'(v_q) - EL_Q;
      end
      default: ;
    endcase
  end

  assign prod     = 48'(mul_a) * 48'(mul_b);
  assign sc_res   = sc(prod);
  assign gate_res = clamp_gate(sc_res);

  always_comb begin
    i_net = 34'(iext_r) - 34'(i_na) - 34'(i_k) - 34'(i_l);
    dv    = i_net >>> DT_SHIFT;
    v_sum = 35'(v_q) + 35'(dv);
    if (v_sum > 35'sd32767)       v_new = 16'sh7FFF;
    else if (v_sum < -35'sd32768) v_new = -16'sh8000;
    else                          v_new = v_sum[15:0];
    spike_now = (v_mv < SPK_MV) && ((v_new >>> 6) >= SPK_MV);
  end

  assign v_mv = v_q >>> 6;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= V_RST_Q;
      out_valid <= 1'b0;
      spike     <= 1'b0;
      m_r       <= '0;
      h_r       <= '0;
      n_r       <= '0;
      iext_r    <= '0;
      ga        <= '0;
      gb        <= '0;
      i_na      <= '0;
      i_k       <= '0;
      i_l       <= '0;
`ifdef HH_SPIKE_COUNT_EN
      spike_count <= 8'd0;
`endif
    end else begin
      out_valid <= 1'b0;
      spike     <= 1'b0;
      if (accept) begin
        m_r    <= clamp_in(m_in);
        h_r    <= clamp_in(h_in);
        n_r    <= clamp_in(n_in);
        iext_r <= i_ext;
      end
      case (state)
        S_M2, S_M3, S_MH: ga <= gate_res;
        S_N2, S_N4:       gb <= gate_res;
        S_INA:            i_na <= sc_res[31:0];
        S_IK:             i_k  <= sc_res[31:0];
        S_IL:             i_l  <= sc_res[31:0];
        S_SUM: begin
          v_q       <= v_new;
          out_valid <= 1'b1;
          spike     <= spike_now;
`ifdef HH_SPIKE_COUNT_EN
          if (spike_now && spike_count != 8'd255) spike_count <= spike_count + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hh_membrane_update.sv
// tb/tb_hh_membrane_update.sv - self-checking bench for hh_membrane_update
module tb_hh_membrane_update;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        m_in = '0, h_in = '0, n_in = '0;
  logic signed [15:0] i_ext = '0;
  logic               out_valid;
  logic signed [15:0] v_q, v_mv;
  logic               spike;
`ifdef HH_SPIKE_COUNT_EN
  logic [7:0]         spike_count;
`endif

  int checks = 0;
  int failures = 0;

  hh_membrane_update dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .m_in(m_in), .h_in(h_in), .n_in(n_in), .i_ext(i_ext),
    .out_valid(out_valid), .v_q(v_q), .v_mv(v_mv), .spike(spike)
`ifdef HH_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint sc(input longint x);
    return (x * 1049 + 524288) >>> 20;
  endfunction

  function automatic longint cl(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic longint model_next(input longint v, input longint m0, input longint h0,
                                        input longint n0, input longint i);
    longint m, h, n, w_na, w_k, n2, ina, ik, il;
    m = cl(m0, 0, 1000); h = cl(h0, 0, 1000); n = cl(n0, 0, 1000);
    w_na = cl(sc(cl(sc(cl(sc(m * m), 0, 1000) * m), 0, 1000) * h), 0, 1000);
    n2   = cl(sc(n * n), 0, 1000);
    w_k  = cl(sc(n2 * n2), 0, 1000);
    ina  = sc(120 * w_na * (v - 50 * 64));
    ik   = sc(36 * w_k * (v + 77 * 64));
    il   = sc(300 * (v + 54 * 64));
    return cl(v + ((i - ina - ik - il) >>> 6), -32768, 32767);
  endfunction

  // Model side: owns accept timing and the queue of pending results.
  int     cyc = 0;
  longint model_v = -4160;
  int     ready_at = 0;
  int     wr = 0;
  longint q_v[64];
  int     q_due[64];
  bit     q_spk[64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    longint nv;
    if (!rst_n) begin
      model_v  = -4160;
      ready_at = 0;
    end else if (in_valid && (cyc + 1 >= ready_at)) begin
      nv = model_next(model_v, longint'(m_in), longint'(h_in), longint'(n_in), longint'(i_ext));
      q_v[wr % 64]   = nv;
      q_due[wr % 64] = cyc + 1 + 9;
      q_spk[wr % 64] = ((model_v >>> 6) < 0) && ((nv >>> 6) >= 0);
      wr++;
      model_v  = nv;
      ready_at = cyc + 1 + 9;
    end
  end

  // Compare side: checks every output on every falling edge.
  int     rd = 0;
  longint shown_v = -4160;
  int     cnt_model = 0;

  always @(negedge clk) begin
    bit ev, es;
    if (!rst_n) begin
      rd = wr;
      shown_v = -4160;
      cnt_model = 0;
      chk("rst_v_q", v_q, -4160);
      chk("rst_v_mv", v_mv, -65);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_spike", spike, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      ev = (rd != wr) && (q_due[rd % 64] == cyc);
      es = 1'b0;
      chk("out_valid", out_valid, ev);
      if (ev) begin
        shown_v = q_v[rd % 64];
        es = q_spk[rd % 64];
        rd++;
        if (es && cnt_model < 255) cnt_model++;
      end
      chk("v_q", v_q, shown_v);
      chk("v_mv", v_mv, shown_v >>> 6);
      chk("spike", spike, es);
      chk("in_ready", in_ready, (cyc + 1 >= ready_at));
`ifdef HH_SPIKE_COUNT_EN
      chk("spike_count", spike_count, cnt_model);
`endif
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input int m, input int h, input int n, input int i);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", in_ready, 1);
    m_in = 16'(m); h_in = 16'(h); n_in = 16'(n); i_ext = 16'(i);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_in = 16'hFFFF; h_in = 16'hFFFF; n_in = 16'hFFFF; i_ext = 16'sh7FFF;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, cnt, nout;
  int times[3];
  int vec_m[4] = '{500, 50, 0, 800};
  int vec_h[4] = '{600, 900, 0, 300};
  int vec_n[4] = '{300, 700, 1000, 1200};
  int vec_i[4] = '{640, -1000, 32767, -32768};

  initial begin
    chk("pin_leak", model_next(-4160, 0, 0, 0, 0), -4157);
    chk("pin_na", model_next(-4160, 1000, 1000, 0, 0), 9648);
    chk("pin_clamp", model_next(-4160, 5000, 5000, 0, 0), 9648);

    do_reset();
    chk("reset_v_q", v_q, -4160);
    chk("reset_in_ready", in_ready, 1);

    send(0, 0, 0, 0);
    wait_out(lat);
    chk("leak_latency", lat, 9);
    chk("leak_v_q", v_q, -4157);
    chk("leak_spike", spike, 0);

    do_reset();
    send(1000, 1000, 0, 0);
    wait_out(lat);
    chk("na_latency", lat, 9);
    chk("na_v_q", v_q, 9648);
    chk("na_v_mv", v_mv, 150);
    chk("na_spike", spike, 1);
`ifdef HH_SPIKE_COUNT_EN
    chk("na_spike_count", spike_count, 1);
`endif

    do_reset();
    send(0, 0, 0, 0);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k == 2);
      if (out_valid) cnt++;
    end
    in_valid = 1'b0;
    chk("busy_pulses", cnt, 1);
    chk("busy_v_q", v_q, -4157);

    do_reset();
    send(1000, 1000, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("abort_pulses", cnt, 0);
    chk("abort_v_q", v_q, -4160);

    do_reset();
    @(negedge clk);
    m_in = 16'd5000; h_in = 16'd5000; n_in = 16'd0; i_ext = 16'sd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    nout = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 18) in_valid = 1'b0;
      if (out_valid) begin
        if (nout == 0) chk("clamp_v_q", v_q, 9648);
        if (nout < 3) times[nout] = k;
        nout++;
      end
    end
    chk("b2b_count", nout, 3);
    chk("b2b_first", times[0], 9);
    chk("b2b_gap1", times[1] - times[0], 9);
    chk("b2b_gap2", times[2] - times[1], 9);

    for (int j = 0; j < 4; j++) begin
      send(vec_m[j], vec_h[j], vec_n[j], vec_i[j]);
      wait_out(lat);
      chk("vec_latency", lat, 9);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
